// File: rtl/dt_frame_receiver.sv
// dt_frame_receiver: recovers the async DT TDM stream (f0/c4/data) into a parallel frame; optional rx_overrun via DT_RX_OVERRUN_EN
`timescale 1ns/1ps
module dt_frame_receiver #(
    parameter int FRAME_BITS  = 384,
    parameter int C4_PER_BIT  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk50,
    input  logic                  reset_in_rg,
    input  logic                  f0,
    input  logic                  c4,
    input  logic                  data_from_dt,
    input  logic                  int_ack,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic [7:0]            frame_count,
    output logic                  cpu_int,
`ifdef DT_RX_OVERRUN_EN
    output logic                  rx_overrun,
`endif
    output logic                  sync_err
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int PW = (C4_PER_BIT > 1) ? $clog2(C4_PER_BIT) : 1;
    typedef enum logic {HUNT, RECV} state_t;
    state_t                state, state_n;
    logic [SYNC_STAGES-1:0] f0_sy, c4_sy, d_sy;
    logic                  c4_prev, f0_s, d_s, c4_rise, done, short_f;
    logic [CW-1:0]         bit_cnt, bit_cnt_n;
    logic [PW-1:0]         phase, phase_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n;
    assign f0_s    = f0_sy[SYNC_STAGES-1];
    assign d_s     = d_sy[SYNC_STAGES-1];
    assign c4_rise = c4_sy[SYNC_STAGES-1] & ~c4_prev;
    // f0 low restarts the frame; it only counts as an error once bits have been taken
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        phase_n   = phase;
        shreg_n   = shreg;
        done      = 1'b0;
        short_f   = 1'b0;
        if (c4_rise) begin
            if (!f0_s) begin
                state_n   = RECV;
                short_f   = (state == RECV) && (bit_cnt != '0);
                bit_cnt_n = '0;
                phase_n   = '0;
            end else if (state == RECV) begin
                if (phase == PW'(C4_PER_BIT - 1)) begin
                    shreg_n   = {shreg[FRAME_BITS-2:0], d_s};
                    phase_n   = '0;
                    done      = (bit_cnt == CW'(FRAME_BITS - 1));
                    bit_cnt_n = done ? '0 : bit_cnt + 1'b1;
                    state_n   = done ? HUNT : RECV;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk50 or posedge reset_in_rg) begin
        if (reset_in_rg) begin
            f0_sy       <= '0;
            c4_sy       <= '0;
            d_sy        <= '0;
            c4_prev     <= 1'b0;
            state       <= HUNT;
            bit_cnt     <= '0;
            phase       <= '0;
            shreg       <= '0;
            frame_data  <= '0;
            frame_count <= '0;
            cpu_int     <= 1'b0;
            sync_err    <= 1'b0;
`ifdef DT_RX_OVERRUN_EN
            rx_overrun  <= 1'b0;
`endif
        end else begin
            f0_sy       <= {f0_sy[SYNC_STAGES-2:0], f0};
            c4_sy       <= {c4_sy[SYNC_STAGES-2:0], c4};
            d_sy        <= {d_sy[SYNC_STAGES-2:0], data_from_dt};
            c4_prev     <= c4_sy[SYNC_STAGES-1];
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            phase       <= phase_n;
            shreg       <= shreg_n;
            frame_data  <= done ? shreg_n : frame_data;
            frame_count <= frame_count + {7'd0, done};
            cpu_int     <= done | (cpu_int & ~int_ack);
            sync_err    <= short_f | (sync_err & ~int_ack);
`ifdef DT_RX_OVERRUN_EN
            rx_overrun  <= (done & cpu_int) | (rx_overrun & ~int_ack);
`endif
        end
    end
endmodule

// File: doc/dt_frame_receiver.md
Name: dt_frame_receiver

Overview:
Receive stage on the DT side of the converter datapath. Recovers the serial TDM stream from the DT (frame pulse f0, bit clock c4, data_from_dt), all asynchronous to clk50, and assembles one full frame into a parallel shadow register. Raises cpu_int per completed frame so the CPU/STM side can pick the frame up. Default frame length matches the 384-bit converter delay line downstream.

Parameters:
FRAME_BITS, 384, bits per frame; MSB received first.
C4_PER_BIT, 2, c4 periods per data bit cell; range 1..8.
SYNC_STAGES, 2, flip-flop depth of the input synchronisers; minimum 2.

Ports:
clk50  in  1  system clock, 50 MHz.
reset_in_rg  in  1  asynchronous, active-high reset.
f0  in  1  frame pulse from DT, active low, asynchronous.
c4  in  1  DT bit-rate clock, asynchronous, sampled in the clk50 domain.
data_from_dt  in  1  serial data from DT, asynchronous.
int_ack  in  1  one-clk50 pulse from the CPU; clears cpu_int and sync_err.
frame_data  out  FRAME_BITS  last complete frame; bit FRAME_BITS-1 = first bit received.
frame_count  out  8  completed-frame counter.
cpu_int  out  1  frame-ready interrupt, level.
sync_err  out  1  sticky framing-error flag.

Behaviour:
- Reset is asynchronous, active-high; clock is clk50 only. On reset: frame_data=0, frame_count=0, cpu_int=0, sync_err=0, synchronisers=0, shift register=0, bit_cnt=0, phase=0, state=HUNT.
- f0, c4 and data_from_dt each pass through SYNC_STAGES flops of identical depth, so their alignment is preserved.
- c4_rise = one-cycle pulse when synced c4 is 1 and its previous value is 0. All frame logic advances only on c4_rise.
- FSM with two states:
  - HUNT: on c4_rise with synced f0==0, go to RECV with bit_cnt=0 and phase=0. Data is ignored while in HUNT.
  - RECV: on each c4_rise, phase increments. When phase==C4_PER_BIT-1, sample synced data into the shift register LSB (shift left), set phase=0 and increment bit_cnt.
- Frame completion: when the sample taken is bit number FRAME_BITS (bit_cnt reaches FRAME_BITS), the next clk50 edge does all of the following. Latency is one clk50 cycle after that c4_rise.
  - frame_data is loaded with the full shift register.
  - frame_count is incremented; it wraps 255 -> 0.
  - cpu_int is set to 1.
  - The FSM returns to HUNT.
- Short frame: f0==0 on a c4_rise while in RECV with bit_cnt in 1..FRAME_BITS-1.
  - sync_err is set.
  - The partial frame is discarded; frame_data, frame_count and cpu_int are unchanged.
  - The FSM stays in RECV with bit_cnt=0 and phase=0, treating this pulse as the new frame start.
- f0==0 while in RECV with bit_cnt==0 is a continued or long pulse. It resets phase only and is not an error.
- cpu_int and sync_err clear on int_ack.
  - If int_ack and a set event occur in the same clk50 cycle, set wins and the flag stays 1.
  - If cpu_int is already 1 at completion, frame_data is still overwritten (newest frame wins).
- Assertion of reset_in_rg mid-frame aborts reception immediately and returns every register to its reset value.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
DT_RX_OVERRUN_EN
- Defined: adds output port rx_overrun (1 bit, reset 0). It is set when a frame completes while cpu_int is already 1. It clears on int_ack, with set winning on a simultaneous event. The frame_data overwrite behaviour is unchanged.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
1. Nominal frame: reset, then f0 low pulse, then 384 bits of repeated 0xA5 at C4_PER_BIT=2 with c4=4.096 MHz.
   Required: frame_data={48{8'hA5}}, frame_count=1, cpu_int=1 one clk50 cycle after the final sampling c4_rise, sync_err=0.
2. Acknowledge handling: int_ack pulse after case 1 -> cpu_int=0. Then send a second frame of 0x3C with int_ack asserted in the exact completion cycle -> cpu_int stays 1, frame_count=2.
3. Short frame: f0 pulse, 100 bits, then f0 again, then a full 384-bit frame of 0xFF.
   Required: sync_err=1 at bit 100 while frame_data and frame_count are unchanged. After the full frame, frame_data=all-ones and frame_count increments by 1.
4. Pre-sync data: toggle data_from_dt for 500 c4 cycles with f0 held high -> frame_data=0, frame_count=0, cpu_int=0, state remains HUNT.
5. Mid-frame reset: assert reset_in_rg after 200 bits, release, then send a full frame of 0x81.
   Required: all outputs 0 during reset; the afterwards frame is received intact as {48{8'h81}} with frame_count=1.
6. With DT_RX_OVERRUN_EN defined: two complete frames with no int_ack between them -> rx_overrun=1, frame_data holds the second frame, and int_ack clears both rx_overrun and cpu_int.
